// File: rtl/flash_prog_ctrl_if.sv
// Request/response bus between the device controller and the flash write sequencer.
interface flash_prog_ctrl_if;
   logic        start_i;
   logic        erase_i;
   logic [22:0] addr_i;
   logic [15:0] data_i;
   logic        busy_o;
   logic        done_o;
   logic [7:0]  status_o;
   logic        error_o;

   modport master (
      output start_i, erase_i, addr_i, data_i,
      input  busy_o, done_o, status_o, error_o
   );

   modport slave (
      input  start_i, erase_i, addr_i, data_i,
      output busy_o, done_o, status_o, error_o
   );
endinterface

// File: rtl/flash_prog_ctrl.sv
// CFI program-word / erase-block sequencer for the JS28F640 parallel flash.
// Define FLASH_UNLOCK_EN to prefix every operation with a block-unlock sequence.
//
// state | meaning
// IDLE  | waiting for start, flash pins released
// UNLK1 | write 0x0060 (block lock setup)
// UNLK2 | write 0x00D0 (unlock confirm)
// CMD1  | write 0x0040 program / 0x0020 erase setup
// CMD2  | write program data / 0x00D0 erase confirm
// POLL  | read status register until SR7 or poll limit
// CLR   | write 0x0050 clear status
// ARRAY | write 0x00FF back to read-array mode
// DONE  | one-cycle completion pulse
module flash_prog_ctrl #(
   parameter logic [25:0] POLL_LIMIT = 26'h3FFFFFF
) (
   input  logic             clk25,
   input  logic             rst,
   flash_prog_ctrl_if.slave req,
   input  logic [7:0]       flStat_i,
   output logic [22:0]      flAddr_o,
   output logic [15:0]      flData_o,
   output logic             flDataOe_o,
   output logic             flCE_o,
   output logic             flOE_o,
   output logic             flWE_o,
   output logic             flRst_o,
   output logic             flByte_o,
   output logic             flVpen_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_UNLK1, S_UNLK2, S_CMD1, S_CMD2, S_POLL, S_CLR, S_ARRAY, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic [25:0] poll_cnt_q, poll_cnt_d;
   logic [22:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        erase_q, erase_d;
   logic [7:0]  sr_q, sr_d;
   logic [7:0]  status_q, status_d;
   logic        error_q, error_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ce_q, ce_d;
   logic        oe_q, oe_d;
   logic        we_q, we_d;
   logic        doe_q, doe_d;
   logic [15:0] fl_data_q, fl_data_d;
   logic        fl_rst_q, fl_rst_d;

   function automatic logic is_write(input state_t s);
      return (s == S_UNLK1) || (s == S_UNLK2) || (s == S_CMD1) ||
             (s == S_CMD2) || (s == S_CLR) || (s == S_ARRAY);
   endfunction

   function automatic logic [15:0] cmd_word(input state_t s, input logic er,
                                            input logic [15:0] wd);
      case (s)
         S_UNLK1: return 16'h0060;
         S_UNLK2: return 16'h00D0;
         S_CMD1:  return er ? 16'h0020 : 16'h0040;
         S_CMD2:  return er ? 16'h00D0 : wd;
         S_CLR:   return 16'h0050;
         S_ARRAY: return 16'h00FF;
         default: return 16'h0000;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      poll_cnt_d = poll_cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      erase_d    = erase_q;
      sr_d       = sr_q;
      status_d   = status_q;
      error_d    = error_q;
      case (state_q)
         S_IDLE: begin
            phase_d = 2'd0;
            if (req.start_i) begin
               addr_d     = {req.addr_i[22:1], 1'b0};
               wdata_d    = req.data_i;
               erase_d    = req.erase_i;
               error_d    = 1'b0;
               poll_cnt_d = 26'd0;
`ifdef FLASH_UNLOCK_EN
               state_d    = S_UNLK1;
`else
               state_d    = S_CMD1;
`endif
            end
         end
         S_UNLK1, S_UNLK2, S_CMD1, S_CMD2, S_CLR, S_ARRAY: begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
               phase_d = 2'd0;
               case (state_q)
                  S_UNLK1: state_d = S_UNLK2;
                  S_UNLK2: state_d = S_CMD1;
                  S_CMD1:  state_d = S_CMD2;
                  S_CMD2:  state_d = S_POLL;
                  S_CLR:   state_d = S_ARRAY;
                  default: state_d = S_DONE;
               endcase
            end
         end
         S_POLL: begin
            phase_d = phase_q + 2'd1;
            // SR is captured while OE is still low; the last phase is the CE-high gap.
            if (phase_q == 2'd1) sr_d = flStat_i;
            if (phase_q == 2'd2) begin
               phase_d = 2'd0;
               if (sr_q[7]) begin
                  status_d = sr_q;
                  error_d  = sr_q[5] | sr_q[4] | sr_q[3] | sr_q[1];
                  state_d  = S_CLR;
               end else if (poll_cnt_q + 26'd1 == POLL_LIMIT) begin
                  status_d = 8'h00;
                  error_d  = 1'b1;
                  state_d  = S_CLR;
               end else begin
                  poll_cnt_d = poll_cnt_q + 26'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Pin values are derived from the next state so every output is a flop.
   always_comb begin
      ce_d      = 1'b1;
      oe_d      = 1'b1;
      we_d      = 1'b1;
      doe_d     = 1'b0;
      fl_data_d = fl_data_q;
      fl_rst_d  = 1'b1;
      busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d    = (state_d == S_DONE);
      if (is_write(state_d)) begin
         doe_d     = 1'b1;
         ce_d      = (phase_d == 2'd3);
         we_d      = !((phase_d == 2'd1) || (phase_d == 2'd2));
         fl_data_d = cmd_word(state_d, erase_d, wdata_d);
      end else if (state_d == S_POLL) begin
         ce_d = (phase_d == 2'd2);
         oe_d = (phase_d == 2'd2);
      end
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         state_q    <= S_IDLE;
         phase_q    <= 2'd0;
         poll_cnt_q <= 26'd0;
         addr_q     <= 23'd0;
         wdata_q    <= 16'd0;
         erase_q    <= 1'b0;
         sr_q       <= 8'h00;
         status_q   <= 8'h00;
         error_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ce_q       <= 1'b1;
         oe_q       <= 1'b1;
         we_q       <= 1'b1;
         doe_q      <= 1'b0;
         fl_data_q  <= 16'd0;
         fl_rst_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         poll_cnt_q <= poll_cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         erase_q    <= erase_d;
         sr_q       <= sr_d;
         status_q   <= status_d;
         error_q    <= error_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ce_q       <= ce_d;
         oe_q       <= oe_d;
         we_q       <= we_d;
         doe_q      <= doe_d;
         fl_data_q  <= fl_data_d;
         fl_rst_q   <= fl_rst_d;
      end
   end

   assign req.busy_o   = busy_q;
   assign req.done_o   = done_q;
   assign req.status_o = status_q;
   assign req.error_o  = error_q;
   assign flAddr_o     = addr_q;
   assign flData_o     = fl_data_q;
   assign flDataOe_o   = doe_q;
   assign flCE_o       = ce_q;
   assign flOE_o       = oe_q;
   assign flWE_o       = we_q;
   assign flRst_o      = fl_rst_q;
   assign flByte_o     = 1'b1;
   assign flVpen_o     = 1'b1;

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Scoreboard bench for flash_prog_ctrl: a flash status model, a write monitor and a done monitor.
module tb_flash_prog_ctrl;

   localparam logic [25:0] TB_POLL_LIMIT = 26'd6;
`ifdef FLASH_UNLOCK_EN
   localparam int UNLK = 8;
`else
   localparam int UNLK = 0;
`endif

   typedef struct packed {
      logic [7:0]  st;
      logic        err;
      logic [31:0] lat;
      logic [31:0] reads;
   } exp_t;

   typedef struct packed {
      logic [22:0] addr;
      logic [15:0] data;
   } wr_t;

   logic        clk25 = 1'b0;
   logic        rst   = 1'b1;
   logic [7:0]  fl_stat;
   logic [22:0] fl_addr;
   logic [15:0] fl_data;
   logic        fl_doe, fl_ce, fl_oe, fl_we, fl_rst, fl_byte, fl_vpen;

   flash_prog_ctrl_if bus ();

   flash_prog_ctrl #(.POLL_LIMIT(TB_POLL_LIMIT)) u_dut (
      .clk25      (clk25),
      .rst        (rst),
      .req        (bus.slave),
      .flStat_i   (fl_stat),
      .flAddr_o   (fl_addr),
      .flData_o   (fl_data),
      .flDataOe_o (fl_doe),
      .flCE_o     (fl_ce),
      .flOE_o     (fl_oe),
      .flWE_o     (fl_we),
      .flRst_o    (fl_rst),
      .flByte_o   (fl_byte),
      .flVpen_o   (fl_vpen)
   );

   initial forever #20 clk25 = ~clk25;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   read_cnt = 0;
   int   rd_base = 0;
   int   n_zero = 0;
   int   viol = 0;
   logic [7:0] final_sr = 8'h80;
   exp_t exp_q[$];
   wr_t  wq[$];

   // Flash status model: n_zero reads of 0x00, then final_sr.
   assign fl_stat = ((read_cnt - rd_base) < n_zero) ? 8'h00 : final_sr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
      n_cmp++;
      if (act !== req_v) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, req_v);
      end
   endtask

   initial forever begin
      @(posedge clk25);
      cyc++;
   end

   // Status-read counter and pin protocol check.
   initial begin
      logic prev_oe;
      prev_oe = 1'b1;
      forever begin
         @(negedge clk25);
         if (fl_oe === 1'b1 && prev_oe === 1'b0) read_cnt++;
         if (fl_doe === 1'b1 && fl_oe === 1'b0) viol++;
         prev_oe = fl_oe;
      end
   end

   // Write monitor: every WE# fall is one command write.
   initial begin
      logic prev_we;
      wr_t  w;
      prev_we = 1'b1;
      forever begin
         @(negedge clk25);
         if (fl_we === 1'b0 && prev_we === 1'b1) begin
            if (wq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr %0h data %0h required none", fl_addr, fl_data);
            end else begin
               w = wq.pop_front();
               chk("wr_addr", 32'(fl_addr), 32'(w.addr));
               chk("wr_data", 32'(fl_data), 32'(w.data));
               chk("wr_doe", 32'(fl_doe), 32'd1);
               chk("wr_ce", 32'(fl_ce), 32'd0);
            end
         end
         prev_we = fl_we;
      end
   end

   // Done monitor: pops the expected result whenever done_o pulses.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk25);
         if (bus.done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done with status %0h required no done", bus.status_o);
            end else begin
               e = exp_q.pop_front();
               chk("status", 32'(bus.status_o), 32'(e.st));
               chk("error", 32'(bus.error_o), 32'(e.err));
               chk("latency", 32'(cyc - start_cyc), e.lat);
               chk("reads", 32'(read_cnt - rd_base), e.reads);
               chk("busy_at_done", 32'(bus.busy_o), 32'd0);
               chk("pending_writes", 32'(wq.size()), 32'd0);
               @(negedge clk25);
               chk("done_one_cycle", 32'(bus.done_o), 32'd0);
            end
         end
      end
   end

   task automatic push_wr(input logic [22:0] a, input logic [15:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      wq.push_back(w);
   endtask

   task automatic issue(input logic er, input logic [22:0] a, input logic [15:0] d,
                        input int nz, input logic [7:0] fsr, input bit full,
                        input int nreads, input logic [7:0] st, input logic err);
      logic [22:0] wa;
      exp_t e;
      wa = {a[22:1], 1'b0};
      rd_base  = read_cnt;
      n_zero   = nz;
      final_sr = fsr;
      if (UNLK != 0) begin
         push_wr(wa, 16'h0060);
         push_wr(wa, 16'h00D0);
      end
      push_wr(wa, er ? 16'h0020 : 16'h0040);
      push_wr(wa, er ? 16'h00D0 : d);
      if (full) begin
         push_wr(wa, 16'h0050);
         push_wr(wa, 16'h00FF);
         e.st    = st;
         e.err   = err;
         e.lat   = 32'(17 + 3 * nreads + UNLK);
         e.reads = 32'(nreads);
         exp_q.push_back(e);
      end
      bus.erase_i = er;
      bus.addr_i  = a;
      bus.data_i  = d;
      bus.start_i = 1'b1;
      start_cyc   = cyc;
      @(posedge clk25);
      #1 bus.start_i = 1'b0;
      @(negedge clk25);
      chk("busy_rise", 32'(bus.busy_o), 32'd1);
      chk("err_clr_on_start", 32'(bus.error_o), 32'd0);
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk25);
      end
      chk({nm, "_done_seen"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk25);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish required finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start_i = 1'b0;
      bus.erase_i = 1'b0;
      bus.addr_i  = 23'd0;
      bus.data_i  = 16'd0;
      repeat (3) @(negedge clk25);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_done", 32'(bus.done_o), 32'd0);
      chk("rst_status", 32'(bus.status_o), 32'd0);
      chk("rst_error", 32'(bus.error_o), 32'd0);
      chk("rst_strobes", 32'({fl_ce, fl_oe, fl_we}), 32'h7);
      chk("rst_doe", 32'(fl_doe), 32'd0);
      chk("rst_addr", 32'(fl_addr), 32'd0);
      chk("rst_data", 32'(fl_data), 32'd0);
      chk("rst_flrst", 32'(fl_rst), 32'd0);
      chk("byte_vpen", 32'({fl_byte, fl_vpen}), 32'h3);
      rst = 1'b0;
      @(negedge clk25);
      chk("flrst_release", 32'(fl_rst), 32'd1);

      // Program, SR ready on first read.
      issue(1'b0, 23'h000100, 16'h1234, 0, 8'h80, 1'b1, 1, 8'h80, 1'b0);
      wait_idle("prog_basic");

      // Erase, five busy reads then ready on the read that hits the limit.
      issue(1'b1, 23'h7E0000, 16'h0000, 5, 8'h80, 1'b1, 6, 8'h80, 1'b0);
      wait_idle("erase_slow");

      // Erase failure.
      issue(1'b1, 23'h020000, 16'h0000, 0, 8'hA0, 1'b1, 1, 8'hA0, 1'b1);
      wait_idle("erase_fail");

      // Timeout: SR stuck busy.
      issue(1'b0, 23'h000200, 16'hCAFE, 1000, 8'h80, 1'b1, int'(TB_POLL_LIMIT), 8'h00, 1'b1);
      wait_idle("timeout");

      // Odd address, extra start pulsed during POLL is ignored.
      issue(1'b0, 23'h012345, 16'hBEEF, 2, 8'h80, 1'b1, 3, 8'h80, 1'b0);
      repeat (9 + UNLK) @(negedge clk25);
      chk("oe_low_in_poll", 32'(fl_oe), 32'd0);
      bus.start_i = 1'b1;
      @(negedge clk25);
      bus.start_i = 1'b0;
      wait_idle("start_in_poll");

      // Reset during CMD2 phase 2.
      issue(1'b0, 23'h000400, 16'h1111, 0, 8'h80, 1'b0, 1, 8'h80, 1'b0);
      repeat (6 + UNLK) @(negedge clk25);
      chk("we_low_cmd2", 32'(fl_we), 32'd0);
      rst = 1'b1;
      @(negedge clk25);
      chk("midrst_strobes", 32'({fl_ce, fl_oe, fl_we}), 32'h7);
      chk("midrst_doe", 32'(fl_doe), 32'd0);
      chk("midrst_busy", 32'(bus.busy_o), 32'd0);
      chk("midrst_flrst", 32'(fl_rst), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk25);
      chk("midrst_pending", 32'(wq.size()), 32'd0);

      // Complete program after reset; SR1 set reports an error.
      issue(1'b0, 23'h400002, 16'h5A5A, 0, 8'h82, 1'b1, 1, 8'h82, 1'b1);
      wait_idle("after_reset");

      chk("oe_doe_overlap", 32'(viol), 32'd0);
      chk("final_pending_writes", 32'(wq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
